ysyx_22040088_ifu: RTL and testbench
====================================

Name: ysyx_22040088_ifu

Overview:
- Instruction fetch unit. It is the producer end of the decode interface.
- Holds the architectural PC and issues a read to instruction memory over an AXI-lite style AR/R channel pair.
- Presents {pc, inst} to the decode stage with a valid/ready handshake.
- Takes the decoder's nextpc on handshake completion and loops back to fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- ADDR_W, 64, width of pc, nextpc and araddr.
- DATA_W, 64, memory read data width; must be 64.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- araddr  out  ADDR_W  read address, 8-byte aligned: {pc[63:3],3'b0}.
- arvalid  out  1  read request valid.
- arready  in  1  memory accepts request.
- rdata  in  DATA_W  read data.
- rresp  in  2  read response; 2'b00 means OKAY, anything else is an error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst_valid  out  1  pc/inst/fetch_err valid to decode.
- inst_ready  in  1  decode/execute done; nextpc is valid this cycle.
- pc  out  ADDR_W  PC of the presented instruction.
- inst  out  32  fetched instruction word.
- nextpc  in  ADDR_W  next PC, sampled on the inst_valid&&inst_ready edge.
- fetch_err  out  1  bus error on this fetch; qualified by inst_valid.

Behaviour:
- States: S_IDLE, S_REQ, S_RESP, S_ISSUE.
- Reset (rst==0 at a rising edge):
  - state=S_IDLE, pc=RESET_PC, inst=32'h0, fetch_err=0.
  - arvalid=0, rready=0, inst_valid=0.
  - Reset mid-fetch abandons the transaction. Memory shares rst. rvalid is ignored outside S_RESP.
- S_IDLE: the next edge with rst==1 goes to S_REQ. This gives one bubble after reset release.
- S_REQ:
  - arvalid=1 and araddr={pc[63:3],3'b0}; both are held stable until arready.
  - arvalid&&arready at an edge: go to S_RESP.
  - arvalid is never withdrawn before acceptance.
- S_RESP:
  - rready=1, arvalid=0.
  - On rvalid, latch inst = pc[2] ? rdata[63:32] : rdata[31:0] and fetch_err=(rresp!=2'b00), then go to S_ISSUE.
- S_ISSUE:
  - inst_valid=1. pc, inst and fetch_err are held stable while inst_ready==0.
  - inst_valid&&inst_ready at an edge: pc<=nextpc, fetch_err<=0, go to S_REQ.
  - inst_valid does not depend on inst_ready, so there is no combinational path.
- Latency: with arready and rvalid each high on first opportunity, inst_valid rises 2 cycles after entering S_REQ. Back-to-back fetch period is 3 cycles minimum.
- Outputs are decoded from state only (Moore), except araddr/pc, which come from the pc register.
- The PC updates only in S_ISSUE on handshake; no other path writes it.
- nextpc is taken verbatim; no alignment or width truncation.
- pc[1:0]!=0 with the feature off: the bus address ignores bits [2:0] and inst selection uses pc[2] only.
- arready asserted outside S_REQ and rvalid asserted outside S_RESP have no effect.

Optional Feature:
- Macro: YSYX_22040088_IFU_MISALIGN_EN.
- Defined: in S_REQ, if pc[1:0]!=2'b00, no bus request is made (arvalid stays 0). The next edge goes directly to S_ISSUE with inst=32'h0 and fetch_err=1.
- Undefined: no check; behaviour as above.

Decomposition:
- Shared package ysyx_22040088_pkg:
  - ifu state enum (2 bits).
  - RESP_OKAY=2'b00.
  - default RESET_PC constant.
  - INST_W=32.
- One natural sub-module: ysyx_22040088_pcreg, the PC register with synchronous active-low reset to RESET_PC and a write enable. The FSM stays in the top.

Test Plan:
- Reset release, arready=1, rvalid one cycle later with rdata=64'h00000297_00100093, rresp=0 -> araddr=64'h80000000, inst_valid high 2 cycles after S_REQ entry, inst=32'h00100093, pc=64'h80000000, fetch_err=0.
- Hold inst_ready=0 for 5 cycles, then pulse with nextpc=64'h80000004 -> inst stable for 5 cycles; next araddr=64'h80000000; the following inst=32'h00000297 (upper word), pc=64'h80000004.
- arready withheld 4 cycles -> arvalid stays 1 and araddr stays unchanged the whole time; no S_RESP entry before acceptance.
- rresp=2'b10 on fetch -> inst_valid=1, fetch_err=1. After handshake with nextpc=64'h80001000, fetch_err=0 and araddr=64'h80001000.
- rst=0 asserted while in S_RESP, rvalid raised the same cycle -> next cycle inst_valid=0, rready=0, pc=RESET_PC. A stray rvalid in S_IDLE/S_REQ causes no latch.
- With YSYX_22040088_IFU_MISALIGN_EN: nextpc=64'h80000006 -> no arvalid, inst_valid with fetch_err=1 and inst=0. Without the macro, the same stimulus gives araddr=64'h80000000 and the upper word is selected.

Source files
------------

// File: rtl/ysyx_22040088_pkg.sv
// Shared types and constants for the ysyx_22040088 fetch slice.
package ysyx_22040088_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ISSUE
  } ifu_state_e;

  // Picks the 32-bit half of a 64-bit beat addressed by pc[2].
  function automatic logic [INST_W-1:0] sel_inst(input logic hi, input logic [63:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040088_pcreg.sv
// Architectural PC register: synchronous active-low reset to RESET_PC, written only when we is set.
module ysyx_22040088_pcreg
  import ysyx_22040088_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: AR/R read of the current PC, then presents {pc, inst} to decode.
// Optional feature: YSYX_22040088_IFU_MISALIGN_EN reports pc[1:0]!=0 as a fetch error without a bus read.
module ysyx_22040088_ifu
  import ysyx_22040088_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  input  logic [ADDR_W-1:0] nextpc,
  output logic              fetch_err
);

  ifu_state_e state;
  logic       pc_we;
  logic       req_ok;
  logic       req_ok_next;

  assign pc_we  = inst_valid && inst_ready;
  assign araddr = {pc[ADDR_W-1:3], 3'b000};

`ifdef YSYX_22040088_IFU_MISALIGN_EN
  assign req_ok      = (pc[1:0] == 2'b00);
  assign req_ok_next = (nextpc[1:0] == 2'b00);
`else
  assign req_ok      = 1'b1;
  assign req_ok_next = 1'b1;
`endif

  ysyx_22040088_pcreg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC[ADDR_W-1:0])
  ) u_pcreg (
    .clk(clk),
    .rst(rst),
    .we (pc_we),
    .d  (nextpc),
    .q  (pc)
  );

  // arvalid is armed on the edge that enters S_REQ, so it must look at the PC being loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      fetch_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state   <= S_REQ;
          arvalid <= req_ok;
        end
        S_REQ: begin
          if (!req_ok) begin
            state      <= S_ISSUE;
            arvalid    <= 1'b0;
            inst       <= '0;
            fetch_err  <= 1'b1;
            inst_valid <= 1'b1;
          end else if (arready) begin
            state   <= S_RESP;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rvalid) begin
            state      <= S_ISSUE;
            rready     <= 1'b0;
            inst       <= sel_inst(pc[2], rdata[63:0]);
            fetch_err  <= (rresp != RESP_OKAY);
            inst_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            state      <= S_REQ;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            arvalid    <= req_ok_next;
          end
        end
        default: begin
          state      <= S_IDLE;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Self-checking bench for ysyx_22040088_ifu: directed fetches followed by randomized transactions.
module tb_ysyx_22040088_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] pc;
  logic [31:0] inst;
  logic [63:0] nextpc;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_pc;

  ysyx_22040088_ifu dut (
    .clk       (clk),
    .rst       (rst),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pc        (pc),
    .inst      (inst),
    .nextpc    (nextpc),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a fetch reads the 8-byte beat containing pc, returns the half chosen by pc[2],
  // flags any non-OKAY response, and after the decode handshake the PC becomes nextpc verbatim.
  // Called while the DUT sits in S_REQ with exp_pc as its PC.
  task automatic do_fetch(input int ar_delay, input int r_delay, input logic [63:0] data,
                          input logic [1:0] resp, input int issue_delay, input logic [63:0] npc);
    logic [63:0] exp_addr;
    logic [31:0] exp_inst;
    exp_addr = exp_pc & ~64'h7;
    exp_inst = exp_pc[2] ? data[63:32] : data[31:0];
    check("req_arvalid", {63'd0, arvalid}, 64'd1);
    check("req_araddr", araddr, exp_addr);
    check("req_pc", pc, exp_pc);
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      rvalid = $urandom_range(0, 1);
      tick();
      check("hold_arvalid", {63'd0, arvalid}, 64'd1);
      check("hold_araddr", araddr, exp_addr);
      check("hold_rready", {63'd0, rready}, 64'd0);
    end
    rvalid = 1'b0;
    arready = 1'b1;
    tick();
    check("resp_rready", {63'd0, rready}, 64'd1);
    check("resp_arvalid", {63'd0, arvalid}, 64'd0);
    check("resp_inst_valid", {63'd0, inst_valid}, 64'd0);
    for (int i = 0; i < r_delay; i++) begin
      arready = $urandom_range(0, 1);
      rdata = {$urandom, $urandom};
      tick();
      check("rwait_rready", {63'd0, rready}, 64'd1);
      check("rwait_inst_valid", {63'd0, inst_valid}, 64'd0);
    end
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = data;
    rresp = resp;
    tick();
    rvalid = 1'b0;
    rdata = {$urandom, $urandom};
    rresp = 2'($urandom);
    check("issue_inst_valid", {63'd0, inst_valid}, 64'd1);
    check("issue_inst", {32'd0, inst}, {32'd0, exp_inst});
    check("issue_fetch_err", {63'd0, fetch_err}, {63'd0, resp != 2'b00});
    check("issue_pc", pc, exp_pc);
    for (int i = 0; i < issue_delay; i++) begin
      inst_ready = 1'b0;
      nextpc = {$urandom, $urandom};
      rvalid = $urandom_range(0, 1);
      arready = $urandom_range(0, 1);
      tick();
      check("stall_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("stall_inst", {32'd0, inst}, {32'd0, exp_inst});
      check("stall_pc", pc, exp_pc);
    end
    rvalid = 1'b0;
    arready = 1'b0;
    inst_ready = 1'b1;
    nextpc = npc;
    tick();
    inst_ready = 1'b0;
    nextpc = {$urandom, $urandom};
    exp_pc = npc;
    check("done_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("done_fetch_err", {63'd0, fetch_err}, 64'd0);
    check("done_pc", pc, npc);
  endtask

  initial begin
    rst = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    inst_ready = 1'b0;
    nextpc = '0;
    tick();
    tick();
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", {32'd0, inst}, 64'd0);
    check("rst_fetch_err", {63'd0, fetch_err}, 64'd0);

    // One bubble in S_IDLE after release.
    rst = 1'b1;
    check("bubble_arvalid", {63'd0, arvalid}, 64'd0);
    tick();
    exp_pc = RST_PC;

    do_fetch(0, 0, 64'h00000297_00100093, 2'b00, 5, 64'h80000004);
    do_fetch(4, 0, 64'h00000297_00100093, 2'b00, 0, 64'h80002000);
    do_fetch(0, 2, {$urandom, $urandom}, 2'b10, 1, 64'h80001000);
    do_fetch(1, 1, {$urandom, $urandom}, 2'b00, 0, 64'h80000006);

`ifdef YSYX_22040088_IFU_MISALIGN_EN
    check("mis_arvalid", {63'd0, arvalid}, 64'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("mis_inst_valid", {63'd0, inst_valid}, 64'd1);
    check("mis_fetch_err", {63'd0, fetch_err}, 64'd1);
    check("mis_inst", {32'd0, inst}, 64'd0);
    check("mis_arvalid_issue", {63'd0, arvalid}, 64'd0);
    inst_ready = 1'b1;
    nextpc = 64'h80000010;
    tick();
    inst_ready = 1'b0;
    exp_pc = 64'h80000010;
    check("mis_done_pc", pc, exp_pc);
`else
    do_fetch(0, 0, 64'h11223344_55667788, 2'b00, 0, 64'h80000010);
`endif

    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               $urandom_range(0, 3), {$urandom, $urandom} & ~64'h3);
    end

    // Reset while in S_RESP, with rvalid raised on the same edge.
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("midrst_in_resp", {63'd0, rready}, 64'd1);
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 64'hdeadbeef_cafef00d;
    tick();
    check("midrst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("midrst_rready", {63'd0, rready}, 64'd0);
    check("midrst_pc", pc, RST_PC);
    check("midrst_inst", {32'd0, inst}, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    check("stray_arvalid", {63'd0, arvalid}, 64'd1);
    check("stray_rready", {63'd0, rready}, 64'd0);
    check("stray_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("stray_inst", {32'd0, inst}, 64'd0);
    rvalid = 1'b0;
    exp_pc = RST_PC;
    do_fetch(0, 0, 64'h00000297_00100093, 2'b00, 0, 64'h80000008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
